// File: rtl/me_pkg.sv
// Shared definitions for the ME (memory) stage: load opcodes, EX->ME bus control offsets, FSM states.
package me_pkg;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b101;
    localparam logic [2:0] LD_HU = 3'b110;

    // Control-field offsets above the dest field of the EX->ME bus.
    localparam int unsigned CTRL_GR_WE = 0;
    localparam int unsigned CTRL_LD_OP = 1;
    localparam int unsigned CTRL_REQ   = 4;
    localparam int unsigned CTRL_RFM   = 5;
    localparam int unsigned CTRL_W     = 6;
    localparam int unsigned LD_OP_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } me_state_e;

endpackage

// File: rtl/me_load_align.sv
// Sub-word load alignment and sign/zero extension of a 32-bit read word.
module me_load_align
    import me_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] w_i,
    input  logic [1:0]        a_i,
    input  logic [2:0]        ld_op_i,
    output logic [DATA_W-1:0] aligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = w_i[{a_i, 3'b000} +: 8];
        // Halfword loads are naturally aligned, so only a[1] picks the half.
        half_sel = w_i[{a_i[1], 4'b0000} +: 16];
        case (ld_op_i)
            LD_B:    aligned_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_BU:   aligned_o = {{(DATA_W-8){1'b0}}, byte_sel};
            LD_H:    aligned_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LD_HU:   aligned_o = {{(DATA_W-16){1'b0}}, half_sel};
            default: aligned_o = w_i;
        endcase
    end

endmodule

// File: rtl/me_stage_lsu.sv
// ME pipeline stage: split-transaction data SRAM response handling, response buffer,
// flush drain counter, load alignment, and forwarding/interlock status for ID.
module me_stage_lsu
    import me_pkg::*;
#(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEST_W    = 5,
    parameter int unsigned HANDSHAKE = 1,
    parameter int unsigned CANCEL_W  = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              EX_to_ME_Valid,
    input  logic [PC_W+DATA_W+DEST_W+CTRL_W-1:0] EX_to_ME_Bus,
    output logic                              ME_Allow_in,
    input  logic                              data_sram_data_ok,
    input  logic [DATA_W-1:0]                 data_sram_rdata,
    input  logic                              WB_Allow_in,
    output logic                              ME_to_WB_Valid,
    output logic [PC_W+DEST_W+DATA_W:0]       ME_to_WB_Bus,
    output logic [DEST_W-1:0]                 ME_dest,
    output logic                              ME_load_pending
);

    localparam int unsigned InW = PC_W + DATA_W + DEST_W + CTRL_W;
    localparam logic [CANCEL_W-1:0] CancelMax = '1;
    localparam logic [CANCEL_W-1:0] CancelOne = {{(CANCEL_W-1){1'b0}}, 1'b1};

    logic [InW-1:0]      bus_q;
    logic                me_valid_q;
    me_state_e           state_q;
    logic                buf_valid_q;
    logic [DATA_W-1:0]   buf_q;
    logic [CANCEL_W-1:0] cancel_cnt_q;

    logic [PC_W-1:0]     pc;
    logic [DATA_W-1:0]   alu_result;
    logic                res_from_mem;
    logic                req_issued;
    logic [2:0]          ld_op;
    logic                gr_we;
    logic [DEST_W-1:0]   dest;
    logic                ex_req;

    logic                resp_ok;
    logic                drop;
    logic                cancel_inc;
    logic                ready_go;
    logic                accept;
    logic                accept_req;
    logic [DATA_W-1:0]   load_word;
    logic [DATA_W-1:0]   aligned;
    logic [DATA_W-1:0]   final_result;

    assign pc           = bus_q[InW-1 -: PC_W];
    assign alu_result   = bus_q[DEST_W+CTRL_W +: DATA_W];
    assign res_from_mem = bus_q[DEST_W+CTRL_RFM];
    assign req_issued   = bus_q[DEST_W+CTRL_REQ];
    assign ld_op        = bus_q[DEST_W+CTRL_LD_OP +: LD_OP_W];
    assign gr_we        = bus_q[DEST_W+CTRL_GR_WE];
    assign dest         = bus_q[DEST_W-1:0];
    assign ex_req       = EX_to_ME_Bus[DEST_W+CTRL_REQ];

    always_comb begin
        resp_ok    = (HANDSHAKE == 0) || (data_sram_data_ok && (cancel_cnt_q == '0));
        drop       = (HANDSHAKE != 0) && data_sram_data_ok && (cancel_cnt_q != '0);
        // Our own request is still in flight when flushed without its response.
        cancel_inc = flush && (state_q == WAIT) && !resp_ok;
        ready_go   = !req_issued || buf_valid_q || ((state_q == WAIT) && resp_ok);
        ME_Allow_in    = !me_valid_q || (ready_go && WB_Allow_in);
        ME_to_WB_Valid = me_valid_q && ready_go && !flush;
        accept     = EX_to_ME_Valid && ME_Allow_in;
        accept_req = accept && ex_req;
        load_word  = buf_valid_q ? buf_q : data_sram_rdata;
        final_result    = res_from_mem ? aligned : alu_result;
        ME_to_WB_Bus    = {pc, gr_we, dest, final_result};
        ME_dest         = (me_valid_q && gr_we) ? dest : '0;
        ME_load_pending = me_valid_q && res_from_mem && !ready_go;
    end

    me_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .w_i       (load_word),
        .a_i       (alu_result[1:0]),
        .ld_op_i   (ld_op),
        .aligned_o (aligned)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_q        <= '0;
            me_valid_q   <= 1'b0;
            state_q      <= IDLE;
            buf_valid_q  <= 1'b0;
            buf_q        <= '0;
            cancel_cnt_q <= '0;
        end else begin
            if (accept) begin
                bus_q <= EX_to_ME_Bus;
            end
            if (flush) begin
                me_valid_q <= 1'b0;
            end else if (ME_Allow_in) begin
                me_valid_q <= EX_to_ME_Valid;
            end

            if (cancel_inc && !drop && (cancel_cnt_q != CancelMax)) begin
                cancel_cnt_q <= cancel_cnt_q + CancelOne;
            end else if (drop && !cancel_inc) begin
                cancel_cnt_q <= cancel_cnt_q - CancelOne;
            end

            if (flush) begin
                state_q     <= IDLE;
                buf_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept_req) begin
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (resp_ok) begin
                            if (WB_Allow_in) begin
                                state_q <= accept_req ? WAIT : IDLE;
                            end else begin
                                state_q     <= HOLD;
                                buf_q       <= data_sram_rdata;
                                buf_valid_q <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (WB_Allow_in) begin
                            buf_valid_q <= 1'b0;
                            state_q     <= accept_req ? WAIT : IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
